// File: rtl/demux_conductual_1x4_4bits_pkg.sv
// Shared constants for the 1x4 bus demux: default width, lane indices
// (same order as the 4x1 mux selector) and the data reset value.
package demux_conductual_1x4_4bits_pkg;

    localparam int BUS_WIDTH_DEF = 4;

    // Lane index constants, matching the mux selector encoding
    localparam logic [1:0] LANE1 = 2'd0;
    localparam logic [1:0] LANE2 = 2'd1;
    localparam logic [1:0] LANE3 = 2'd2;
    localparam logic [1:0] LANE4 = 2'd3;

    localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/demux_conductual_1x4_4bits_if.sv
// Bus bundle between the link receive logic and the 1x4 demux.
// slave  : the demux side (consumes the input word, drives the lanes)
// master : the side that feeds the demux and watches the lanes
interface demux_conductual_1x4_4bits_if
    import demux_conductual_1x4_4bits_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF
);
    logic                 valid_in;
    logic [BUS_WIDTH-1:0] bus_in;
    logic [1:0]           selector_2bits;
    logic [BUS_WIDTH-1:0] out1, out2, out3, out4;
    logic                 valid_out1, valid_out2, valid_out3, valid_out4;

    modport slave (
        input  valid_in, bus_in, selector_2bits,
        output out1, out2, out3, out4,
        output valid_out1, valid_out2, valid_out3, valid_out4
    );

    modport master (
        output valid_in, bus_in, selector_2bits,
        input  out1, out2, out3, out4,
        input  valid_out1, valid_out2, valid_out3, valid_out4
    );
endinterface

// File: rtl/demux_conductual_1x2_4bits.sv
// Registered 1x2 demux: steers a valid word to path A (selector=0) or
// path B (selector=1). A data register loads only when its path gets a
// valid word; the pass bit rides along with valid words so the next tree
// level can use it as its own select.
module demux_conductual_1x2_4bits
    import demux_conductual_1x4_4bits_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
    input  logic                 clok,
    input  logic                 reset_L,
    input  logic                 valid_in,
    input  logic [BUS_WIDTH-1:0] bus_in,
    input  logic                 selector,
    input  logic                 pass_in,
    output logic [BUS_WIDTH-1:0] out_a,
    output logic [BUS_WIDTH-1:0] out_b,
    output logic                 valid_a,
    output logic                 valid_b,
    output logic                 pass_out
);
    logic w_ld_a;
    logic w_ld_b;

    assign w_ld_a = valid_in & ~selector;
    assign w_ld_b = valid_in &  selector;

    // Valid strobes: single-cycle pulse per word, cleared otherwise
    always_ff @(posedge clok or negedge reset_L) begin
        if (!reset_L) begin
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            valid_a <= w_ld_a;
            valid_b <= w_ld_b;
        end
    end

    // Data and pass bit: load only on a valid word, hold otherwise
    always_ff @(posedge clok or negedge reset_L) begin
        if (!reset_L) begin
            out_a    <= {BUS_WIDTH{DATA_RST_BIT}};
            out_b    <= {BUS_WIDTH{DATA_RST_BIT}};
            pass_out <= 1'b0;
        end else begin
            if (w_ld_a)   out_a    <= bus_in;
            if (w_ld_b)   out_b    <= bus_in;
            if (valid_in) pass_out <= pass_in;
        end
    end
endmodule

// File: rtl/demux_conductual_1x4_4bits.sv
// 1x4 valid-qualified bus demux built as a two-level registered 1x2 tree.
// Stage 1 splits on sel[0] and carries sel[1] with the word; stage 2
// splits each path on that registered bit. Latency is two clok cycles.
// Optional build macro DEMUX_ROUND_ROBIN_EN replaces selector_2bits with
// an internal lane counter that advances on every valid word.
module demux_conductual_1x4_4bits
    import demux_conductual_1x4_4bits_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
    input  logic                           clok,
    input  logic                           reset_L,
    demux_conductual_1x4_4bits_if.slave    bus
);
    logic [1:0]           w_sel;
    logic [BUS_WIDTH-1:0] w_data_a, w_data_b;
    logic                 w_vld_a, w_vld_b;
    logic                 w_sel1;

`ifdef DEMUX_ROUND_ROBIN_EN
    logic [1:0] r_lane_cnt;

    // Lane counter: advances once per valid word, wraps 3->0
    always_ff @(posedge clok or negedge reset_L) begin
        if (!reset_L)          r_lane_cnt <= LANE1;
        else if (bus.valid_in) r_lane_cnt <= r_lane_cnt + 2'd1;
    end

    // The word uses the count before this cycle's increment
    assign w_sel = r_lane_cnt;
`else
    assign w_sel = bus.selector_2bits;
`endif

    // Stage 1: split on sel[0], carry sel[1] along with the word
    demux_conductual_1x2_4bits #(.BUS_WIDTH(BUS_WIDTH)) u_stage1 (
        .clok     (clok),
        .reset_L  (reset_L),
        .valid_in (bus.valid_in),
        .bus_in   (bus.bus_in),
        .selector (w_sel[0]),
        .pass_in  (w_sel[1]),
        .out_a    (w_data_a),
        .out_b    (w_data_b),
        .valid_a  (w_vld_a),
        .valid_b  (w_vld_b),
        .pass_out (w_sel1)
    );

    // Stage 2, path A (even lanes): out1 / out3
    demux_conductual_1x2_4bits #(.BUS_WIDTH(BUS_WIDTH)) u_stage2_a (
        .clok     (clok),
        .reset_L  (reset_L),
        .valid_in (w_vld_a),
        .bus_in   (w_data_a),
        .selector (w_sel1),
        .pass_in  (1'b0),
        .out_a    (bus.out1),
        .out_b    (bus.out3),
        .valid_a  (bus.valid_out1),
        .valid_b  (bus.valid_out3),
        .pass_out ()
    );

    // Stage 2, path B (odd lanes): out2 / out4
    demux_conductual_1x2_4bits #(.BUS_WIDTH(BUS_WIDTH)) u_stage2_b (
        .clok     (clok),
        .reset_L  (reset_L),
        .valid_in (w_vld_b),
        .bus_in   (w_data_b),
        .selector (w_sel1),
        .pass_in  (1'b0),
        .out_a    (bus.out2),
        .out_b    (bus.out4),
        .valid_a  (bus.valid_out2),
        .valid_b  (bus.valid_out4),
        .pass_out ()
    );
endmodule

// File: tb/tb_demux_conductual_1x4_4bits.sv
// Directed bench for the 1x4 demux. Inputs change at negedge, outputs are
// sampled 1 time unit after the rising edge. Lanes are checked as packed
// vectors: valids {v4,v3,v2,v1} and data {out4,out3,out2,out1}.
// With DEMUX_ROUND_ROBIN_EN defined the round-robin sequence runs instead.
module tb_demux_conductual_1x4_4bits;
    import demux_conductual_1x4_4bits_pkg::*;

    logic clok;
    logic reset_L;
    int   n_cmp;
    int   n_err;

    demux_conductual_1x4_4bits_if #(.BUS_WIDTH(4)) dif ();

    demux_conductual_1x4_4bits #(.BUS_WIDTH(4)) dut (
        .clok    (clok),
        .reset_L (reset_L),
        .bus     (dif.slave)
    );

    initial clok = 1'b0;
    always #5 clok = ~clok;

    logic [3:0]  w_vld;
    logic [15:0] w_outs;
    assign w_vld  = {dif.valid_out4, dif.valid_out3, dif.valid_out2, dif.valid_out1};
    assign w_outs = {dif.out4, dif.out3, dif.out2, dif.out1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s);
        @(negedge clok);
        dif.valid_in       = v;
        dif.bus_in         = d;
        dif.selector_2bits = s;
    endtask

    task automatic step();
        @(posedge clok);
        #1;
    endtask

    task automatic expect_lanes(input string tag, input logic [3:0] v, input logic [15:0] o);
        chk({tag, "_vld"}, {28'd0, w_vld}, {28'd0, v});
        chk({tag, "_out"}, {16'd0, w_outs}, {16'd0, o});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        dif.valid_in       = 1'b0;
        dif.bus_in         = 4'h0;
        dif.selector_2bits = 2'd0;
        reset_L            = 1'b0;
        #12;
        expect_lanes("reset", 4'b0000, 16'h0000);
        @(negedge clok);
        reset_L = 1'b1;

`ifdef DEMUX_ROUND_ROBIN_EN
        // Selector held at 3; lanes come from the counter, gap does not advance it
        drive(1'b1, 4'h8, LANE4); step();
        drive(1'b1, 4'h9, LANE4); step();
        expect_lanes("rr_w8", 4'b0001, 16'h0008);
        drive(1'b0, 4'hF, LANE4); step();
        expect_lanes("rr_w9", 4'b0010, 16'h0098);
        drive(1'b1, 4'hA, LANE4); step();
        expect_lanes("rr_gap", 4'b0000, 16'h0098);
        drive(1'b1, 4'hB, LANE4); step();
        expect_lanes("rr_wA", 4'b0100, 16'h0A98);
        drive(1'b1, 4'hC, LANE4); step();
        expect_lanes("rr_wB", 4'b1000, 16'hBA98);
        drive(1'b0, 4'h0, LANE4); step();
        expect_lanes("rr_wC", 4'b0001, 16'hBA9C);
        step();
        expect_lanes("rr_idle", 4'b0000, 16'hBA9C);
`else
        // Single word to lane 3, two-cycle latency
        drive(1'b1, 4'hA, LANE3); step();
        expect_lanes("lat1", 4'b0000, 16'h0000);
        drive(1'b0, 4'h0, LANE1); step();
        expect_lanes("single", 4'b0100, 16'h0A00);
        step();
        expect_lanes("single_hold", 4'b0000, 16'h0A00);

        // Back-to-back words to all four lanes
        drive(1'b1, 4'h1, LANE1); step();
        drive(1'b1, 4'h2, LANE2); step();
        expect_lanes("b2b_1", 4'b0001, 16'h0A01);
        drive(1'b1, 4'h3, LANE3); step();
        expect_lanes("b2b_2", 4'b0010, 16'h0A21);
        drive(1'b1, 4'h4, LANE4); step();
        expect_lanes("b2b_3", 4'b0100, 16'h0321);
        drive(1'b0, 4'hF, LANE2); step();
        expect_lanes("b2b_4", 4'b1000, 16'h4321);

        // Idle cycles with garbage on bus_in and a moving selector
        drive(1'b0, 4'hF, LANE3); step();
        expect_lanes("idle_1", 4'b0000, 16'h4321);
        drive(1'b0, 4'hF, LANE4); step();
        expect_lanes("idle_2", 4'b0000, 16'h4321);
        drive(1'b0, 4'hF, LANE1); step();
        expect_lanes("idle_3", 4'b0000, 16'h4321);

        // Same lane twice in a row
        drive(1'b1, 4'h5, LANE2); step();
        drive(1'b1, 4'h6, LANE2); step();
        expect_lanes("same_5", 4'b0010, 16'h4351);
        drive(1'b0, 4'h0, LANE1); step();
        expect_lanes("same_6", 4'b0010, 16'h4361);
        step();
        expect_lanes("same_idle", 4'b0000, 16'h4361);

        // Selector change right behind an in-flight word must not misroute it
        drive(1'b1, 4'hE, LANE4); step();
        drive(1'b0, 4'h0, LANE1); step();
        expect_lanes("sel_pipe", 4'b1000, 16'hE361);

        // Async reset while 4'h7 sits in stage 1
        drive(1'b1, 4'h7, LANE4); step();
        dif.valid_in = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        expect_lanes("async_rst", 4'b0000, 16'h0000);
        @(negedge clok);
        reset_L = 1'b1;
        step();
        expect_lanes("post_rst1", 4'b0000, 16'h0000);
        step();
        expect_lanes("post_rst2", 4'b0000, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
